// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipelined control unit: opcodes, ALU ops,
// forwarding selects and the per-stage control word.
package ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_NEG  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_BRZ  = 4'b1001;
  localparam logic [3:0] OP_JM   = 4'b1010;
  localparam logic [3:0] OP_BRN  = 4'b1011;
  localparam logic [3:0] OP_LD   = 4'b1110;
  localparam logic [3:0] OP_SVPC = 4'b1111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_INC  = 4'b0001;
  localparam logic [3:0] ALU_NEG  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_PASS = 4'b0100;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] alu_src1;
    logic       alu_src2;
    logic       branch_n;
    logic       branch_z;
    logic       jump;
    logic       jump_mem;
    logic       mem_read;
    logic       mem_write;
    logic [3:0] alu_op;
  } ctrl_t;

  // Bubble / NOP word: everything off, ALU passes through.
  localparam ctrl_t CTRL_DEFAULT = ctrl_t'({11'b0, ALU_PASS});

  // MEM result is younger than WB, so it wins when both match.
  function automatic logic [1:0] fwd_select(input logic mem_hit, input logic wb_hit);
    return mem_hit ? FWD_MEM : (wb_hit ? FWD_WB : FWD_RF);
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// ID-side inputs and control/hazard outputs of the pipelined control unit.
interface pipe_ctrl_unit_if #(
  parameter int OPW  = 4,
  parameter int RAW  = 6,
  parameter int CNTW = 16
);
  import ctrl_pkg::*;

  logic            id_valid;
  logic [OPW-1:0]  id_opcode;
  logic [RAW-1:0]  id_rs;
  logic [RAW-1:0]  id_rt;
  logic [RAW-1:0]  id_rd;
  logic            ex_z;
  logic            ex_n;

  logic            stall;
  logic            flush;
  logic            flush_mem;
  ctrl_t           ex_ctrl;
  ctrl_t           mem_ctrl;
  ctrl_t           wb_ctrl;
  logic            ex_valid;
  logic            mem_valid;
  logic            wb_valid;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;
  logic            illegal;
  logic [CNTW-1:0] stall_cnt;
  logic [CNTW-1:0] flush_cnt;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, id_rd, ex_z, ex_n,
    input  stall, flush, flush_mem, ex_ctrl, mem_ctrl, wb_ctrl,
           ex_valid, mem_valid, wb_valid, fwd_a, fwd_b, illegal,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, id_rd, ex_z, ex_n,
    output stall, flush, flush_mem, ex_ctrl, mem_ctrl, wb_ctrl,
           ex_valid, mem_valid, wb_valid, fwd_a, fwd_b, illegal,
           stall_cnt, flush_cnt
  );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control word plus register-usage flags.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] opcode,
  output ctrl_t          ctrl,
  output logic           illegal,
  output logic           uses_rs,
  output logic           uses_rt,
  output logic           writes_rd
);

  logic [3:0] op4;
  logic       hi_bad;

  assign op4    = opcode[3:0];
  assign hi_bad = (opcode >> 4) != '0;

  // Table decode; illegal opcodes fall back to the NOP word and read nothing.
  always_comb begin
    ctrl      = CTRL_DEFAULT;
    illegal   = 1'b0;
    uses_rs   = 1'b1;
    uses_rt   = 1'b0;
    writes_rd = 1'b0;
    if (hi_bad) begin
      illegal = 1'b1;
      uses_rs = 1'b0;
    end else begin
      case (op4)
        OP_NOP:  uses_rs = 1'b0;
        OP_SVPC: begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_src1  = 2'b01;
          ctrl.alu_src2  = 1'b1;
          uses_rs        = 1'b0;
          writes_rd      = 1'b1;
        end
        OP_LD: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.mem_read   = 1'b1;
          writes_rd       = 1'b1;
        end
        OP_ST: begin
          ctrl.mem_write = 1'b1;
          uses_rt        = 1'b1;
        end
        OP_ADD: begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALU_ADD;
          uses_rt        = 1'b1;
          writes_rd      = 1'b1;
        end
        OP_INC: begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_src1  = 2'b10;
          ctrl.alu_op    = ALU_INC;
          writes_rd      = 1'b1;
        end
        OP_NEG: begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALU_NEG;
          writes_rd      = 1'b1;
        end
        OP_SUB: begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALU_SUB;
          uses_rt        = 1'b1;
          writes_rd      = 1'b1;
        end
        OP_J:    ctrl.jump     = 1'b1;
        OP_BRZ:  ctrl.branch_z = 1'b1;
        OP_BRN:  ctrl.branch_n = 1'b1;
        OP_JM: begin
          ctrl.jump_mem = 1'b1;
          ctrl.mem_read = 1'b1;
        end
        default: begin
          illegal = 1'b1;
          uses_rs = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID decode, EX/MEM/WB control registers,
// load-use stall, branch/jump flush, operand forwarding and event counters.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int OPW  = 4,
  parameter int RAW  = 6,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  pipe_ctrl_unit_if.slave bus
);

  localparam int STAGES = 3;  // vld_pipe index: 1=EX, 2=MEM, 3=WB

  ctrl_t dec_ctrl;
  logic  dec_illegal, dec_rs, dec_rt, dec_wr;

  ctrl_decode #(.OPW(OPW)) u_dec (
    .opcode    (bus.id_opcode),
    .ctrl      (dec_ctrl),
    .illegal   (dec_illegal),
    .uses_rs   (dec_rs),
    .uses_rt   (dec_rt),
    .writes_rd (dec_wr)
  );

  logic [STAGES:1]      vld_pipe_q, vld_pipe_d;
  ctrl_t                ex_ctrl_q, ex_ctrl_d;
  ctrl_t                mem_ctrl_q, mem_ctrl_d;
  ctrl_t                wb_ctrl_q, wb_ctrl_d;
  logic [1:0][RAW-1:0]  ex_src_q, ex_src_d;  // [0]=rs, [1]=rt
  logic [RAW-1:0]       ex_rd_q, ex_rd_d;
  logic [RAW-1:0]       mem_rd_q, mem_rd_d;
  logic [RAW-1:0]       wb_rd_q, wb_rd_d;
  logic                 illegal_q, illegal_d;
  logic [CNTW-1:0]      stall_cnt_q, stall_cnt_d;
  logic [CNTW-1:0]      flush_cnt_q, flush_cnt_d;

  logic                 flush_mem_c, flush_ex_c, flush_c, hazard_c, stall_c, id_take;
  logic [1:0][1:0]      fwd;

  // Redirects and load-use detection; any redirect overrides the stall.
  always_comb begin
    flush_mem_c = vld_pipe_q[2] & mem_ctrl_q.jump_mem;
    flush_ex_c  = vld_pipe_q[1] & (ex_ctrl_q.jump |
                                   (ex_ctrl_q.branch_z & bus.ex_z) |
                                   (ex_ctrl_q.branch_n & bus.ex_n));
    flush_c     = flush_ex_c | flush_mem_c;
    hazard_c    = bus.id_valid & vld_pipe_q[1] & ex_ctrl_q.mem_read & ~ex_ctrl_q.jump_mem &
                  ((dec_rs & (ex_rd_q == bus.id_rs)) | (dec_rt & (ex_rd_q == bus.id_rt)));
    stall_c     = hazard_c & ~flush_c;
  end

  // One forwarding mux select per EX operand.
  for (genvar g = 0; g < 2; g++) begin : g_fwd
    assign fwd[g] = fwd_select(
      vld_pipe_q[2] & mem_ctrl_q.reg_write & ~mem_ctrl_q.mem_to_reg & (mem_rd_q == ex_src_q[g]),
      vld_pipe_q[3] & wb_ctrl_q.reg_write & (wb_rd_q == ex_src_q[g]));
  end

  // Stage advance: bubbles replace whatever a stall or redirect kills.
  // rd is zeroed for non-writers so a stale field can never match.
  always_comb begin
    id_take     = bus.id_valid & ~stall_c & ~flush_c;
    vld_pipe_d  = {vld_pipe_q[2], vld_pipe_q[1] & ~flush_mem_c, id_take};
    ex_ctrl_d   = id_take ? dec_ctrl : CTRL_DEFAULT;
    ex_src_d    = id_take ? {bus.id_rt, bus.id_rs} : '0;
    ex_rd_d     = (id_take & dec_wr) ? bus.id_rd : '0;
    mem_ctrl_d  = flush_mem_c ? CTRL_DEFAULT : ex_ctrl_q;
    mem_rd_d    = flush_mem_c ? '0 : ex_rd_q;
    wb_ctrl_d   = mem_ctrl_q;
    wb_rd_d     = mem_rd_q;
    illegal_d   = id_take & dec_illegal;
    stall_cnt_d = stall_cnt_q;
    if (stall_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNTW'(1);
    flush_cnt_d = flush_cnt_q;
    if (flush_c && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNTW'(1);
  end

  // Stage registers and counters; reset drops all in-flight state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q  <= '0;
      ex_ctrl_q   <= CTRL_DEFAULT;
      mem_ctrl_q  <= CTRL_DEFAULT;
      wb_ctrl_q   <= CTRL_DEFAULT;
      ex_src_q    <= '0;
      ex_rd_q     <= '0;
      mem_rd_q    <= '0;
      wb_rd_q     <= '0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      ex_ctrl_q   <= ex_ctrl_d;
      mem_ctrl_q  <= mem_ctrl_d;
      wb_ctrl_q   <= wb_ctrl_d;
      ex_src_q    <= ex_src_d;
      ex_rd_q     <= ex_rd_d;
      mem_rd_q    <= mem_rd_d;
      wb_rd_q     <= wb_rd_d;
      illegal_q   <= illegal_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall     = stall_c;
  assign bus.flush     = flush_c;
  assign bus.flush_mem = flush_mem_c;
  assign bus.ex_ctrl   = ex_ctrl_q;
  assign bus.mem_ctrl  = mem_ctrl_q;
  assign bus.wb_ctrl   = wb_ctrl_q;
  assign bus.ex_valid  = vld_pipe_q[1];
  assign bus.mem_valid = vld_pipe_q[2];
  assign bus.wb_valid  = vld_pipe_q[3];
  assign bus.fwd_a     = fwd[0];
  assign bus.fwd_b     = fwd[1];
  assign bus.illegal   = illegal_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: instruction-level pipeline model plus directed scenarios.
module tb_pipe_ctrl_unit;
  import ctrl_pkg::*;

  localparam int OPW  = 5;  // one extra opcode bit to reach the upper-bit illegal case
  localparam int RAW  = 6;
  localparam int CNTW = 5;  // small counters so saturation is reachable
  localparam int CMAX = (1 << CNTW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_unit_if #(.OPW(OPW), .RAW(RAW), .CNTW(CNTW)) bus ();

  pipe_ctrl_unit #(.OPW(OPW), .RAW(RAW), .CNTW(CNTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit             v;
    logic [OPW-1:0] op;
    logic [RAW-1:0] rs, rt, rd;
  } ins_t;

  int   vecs = 0;
  int   errs = 0;
  ins_t m_ex, m_mem, m_wb;
  bit   m_ill;
  int   m_scnt, m_fcnt;
  bit   s_stall, s_flush, s_fm;
  int   n_stall;

  function automatic ins_t mk(input bit v, input int op, input int rs, input int rt, input int rd);
    ins_t s;
    s.v  = v;
    s.op = OPW'(op);
    s.rs = RAW'(rs);
    s.rt = RAW'(rt);
    s.rd = RAW'(rd);
    return s;
  endfunction

  function automatic bit is_op(input logic [OPW-1:0] op, input logic [3:0] code);
    return ((op >> 4) == 0) && (op[3:0] == code);
  endfunction

  function automatic bit legal(input logic [OPW-1:0] op);
    return ((op >> 4) == 0) && !(op[3:0] inside {4'b0001, 4'b0010, 4'b1100, 4'b1101});
  endfunction

  function automatic bit reads_rs(input logic [OPW-1:0] op);
    return legal(op) && !is_op(op, 4'b0000) && !is_op(op, 4'b1111);
  endfunction

  function automatic bit reads_rt(input logic [OPW-1:0] op);
    return is_op(op, 4'b0100) || is_op(op, 4'b0111) || is_op(op, 4'b0011);
  endfunction

  function automatic bit writes(input logic [OPW-1:0] op);
    return is_op(op, 4'b1111) || is_op(op, 4'b1110) || is_op(op, 4'b0100) ||
           is_op(op, 4'b0101) || is_op(op, 4'b0110) || is_op(op, 4'b0111);
  endfunction

  // Expected control word, hand-packed from the decode table
  // {rw, m2r, src1[1:0], src2, bn, bz, j, jm, mr, mw, alu[3:0]}.
  function automatic logic [14:0] ctrl_of(input ins_t s);
    if (!s.v || !legal(s.op)) return 15'h0004;
    case (s.op[3:0])
      4'b1111: return 15'h4C04;
      4'b1110: return 15'h6024;
      4'b0011: return 15'h0014;
      4'b0100: return 15'h4000;
      4'b0101: return 15'h5001;
      4'b0110: return 15'h4002;
      4'b0111: return 15'h4003;
      4'b1000: return 15'h0084;
      4'b1001: return 15'h0104;
      4'b1010: return 15'h0064;
      4'b1011: return 15'h0204;
      default: return 15'h0004;
    endcase
  endfunction

  function automatic logic [1:0] fwd_of(input logic [RAW-1:0] r);
    if (m_mem.v && writes(m_mem.op) && !is_op(m_mem.op, 4'b1110) && m_mem.rd == r) return 2'b01;
    if (m_wb.v && writes(m_wb.op) && m_wb.rd == r) return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ex   = mk(0, 0, 0, 0, 0);
    m_mem  = m_ex;
    m_wb   = m_ex;
    m_ill  = 1'b0;
    m_scnt = 0;
    m_fcnt = 0;
  endtask

  // One cycle: drive ID, compare every output against the model, advance the model.
  task automatic step(input ins_t id, input bit z, input bit n, output bit took);
    bit e_fm, e_fx, e_fl, e_hz, e_st, take;
    ins_t bub;
    bub = mk(0, 0, 0, 0, 0);
    @(negedge clk);
    bus.id_valid  = id.v;
    bus.id_opcode = id.op;
    bus.id_rs     = id.rs;
    bus.id_rt     = id.rt;
    bus.id_rd     = id.rd;
    bus.ex_z      = z;
    bus.ex_n      = n;
    #1;
    e_fm = m_mem.v && is_op(m_mem.op, 4'b1010);
    e_fx = m_ex.v && (is_op(m_ex.op, 4'b1000) || (is_op(m_ex.op, 4'b1001) && z) ||
                      (is_op(m_ex.op, 4'b1011) && n));
    e_fl = e_fm || e_fx;
    e_hz = id.v && m_ex.v && is_op(m_ex.op, 4'b1110) &&
           ((reads_rs(id.op) && m_ex.rd == id.rs) || (reads_rt(id.op) && m_ex.rd == id.rt));
    e_st = e_hz && !e_fl;
    chk("stall",     32'(bus.stall),       32'(e_st));
    chk("flush",     32'(bus.flush),       32'(e_fl));
    chk("flush_mem", 32'(bus.flush_mem),   32'(e_fm));
    chk("ex_valid",  32'(bus.ex_valid),    32'(m_ex.v));
    chk("mem_valid", 32'(bus.mem_valid),   32'(m_mem.v));
    chk("wb_valid",  32'(bus.wb_valid),    32'(m_wb.v));
    chk("ex_ctrl",   32'({bus.ex_ctrl}),   32'(ctrl_of(m_ex)));
    chk("mem_ctrl",  32'({bus.mem_ctrl}),  32'(ctrl_of(m_mem)));
    chk("wb_ctrl",   32'({bus.wb_ctrl}),   32'(ctrl_of(m_wb)));
    chk("illegal",   32'(bus.illegal),     32'(m_ill));
    chk("stall_cnt", 32'(bus.stall_cnt),   32'(m_scnt));
    chk("flush_cnt", 32'(bus.flush_cnt),   32'(m_fcnt));
    if (m_ex.v) begin
      chk("fwd_a", 32'(bus.fwd_a), 32'(fwd_of(m_ex.rs)));
      chk("fwd_b", 32'(bus.fwd_b), 32'(fwd_of(m_ex.rt)));
    end
    s_stall = bus.stall;
    s_flush = bus.flush;
    s_fm    = bus.flush_mem;
    n_stall += int'(bus.stall);
    @(posedge clk);
    take  = id.v && !e_st && !e_fl;
    m_wb  = m_mem;
    m_mem = e_fm ? bub : m_ex;
    m_ex  = take ? id : bub;
    m_ill = take && !legal(id.op);
    if (e_st && m_scnt < CMAX) m_scnt++;
    if (e_fl && m_fcnt < CMAX) m_fcnt++;
    took = !e_st;
  endtask

  task automatic issue(input ins_t x, input bit z = 1'b0, input bit n = 1'b0);
    bit took;
    took = 1'b0;
    for (int k = 0; k < 4 && !took; k++) step(x, z, n, took);
    chk("issue_accepted", 32'(took), 32'd1);
  endtask

  task automatic gap(input int nc);
    bit t;
    for (int k = 0; k < nc; k++) step(mk(0, 0, 0, 0, 0), 1'b0, 1'b0, t);
  endtask

  initial begin
    bit t;
    int s0, f0;
    bus.id_valid  = 1'b0;
    bus.id_opcode = '0;
    bus.id_rs     = '0;
    bus.id_rt     = '0;
    bus.id_rd     = '0;
    bus.ex_z      = 1'b0;
    bus.ex_n      = 1'b0;
    model_reset();

    // Reset state
    #7;
    chk("rst_ex_valid",  32'(bus.ex_valid),         32'd0);
    chk("rst_mem_valid", 32'(bus.mem_valid),        32'd0);
    chk("rst_wb_valid",  32'(bus.wb_valid),         32'd0);
    chk("rst_alu_op",    32'(bus.ex_ctrl.alu_op),   32'h4);
    chk("rst_stall_cnt", 32'(bus.stall_cnt),        32'd0);
    chk("rst_flush_cnt", 32'(bus.flush_cnt),        32'd0);
    chk("rst_flush",     32'(bus.flush),            32'd0);
    chk("rst_stall",     32'(bus.stall),            32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // SUB decodes into EX one cycle later
    issue(mk(1, 4'b0111, 1, 2, 3));
    #1;
    chk("sub_alu_op",    32'(bus.ex_ctrl.alu_op),    32'h3);
    chk("sub_reg_write", 32'(bus.ex_ctrl.reg_write), 32'd1);
    gap(3);

    // Load-use: one stall, bubble, then WB forwarding into rs
    n_stall = 0;
    s0 = int'(bus.stall_cnt);
    issue(mk(1, 4'b1110, 1, 0, 5));
    issue(mk(1, 4'b0100, 5, 2, 7));
    #1;
    chk("ldu_fwd_a",        32'(bus.fwd_a), 32'b10);
    chk("ldu_fwd_b",        32'(bus.fwd_b), 32'b00);
    chk("ldu_stall_cycles", 32'(n_stall),   32'd1);
    chk("ldu_stall_cnt",    32'(int'(bus.stall_cnt) - s0), 32'd1);
    gap(3);

    // ALU result forwarded from MEM to both operands, no stall
    n_stall = 0;
    issue(mk(1, 4'b0100, 1, 1, 3));
    issue(mk(1, 4'b0111, 3, 3, 4));
    #1;
    chk("alu_fwd_a",  32'(bus.fwd_a), 32'b01);
    chk("alu_fwd_b",  32'(bus.fwd_b), 32'b01);
    chk("alu_nostall", 32'(n_stall),  32'd0);
    gap(3);

    // BRZ taken / not taken
    issue(mk(1, 4'b1001, 2, 0, 0));
    step(mk(1, 4'b0100, 1, 2, 3), 1'b1, 1'b0, t);
    chk("brz_taken_flush", 32'(s_flush), 32'd1);
    #1;
    chk("brz_taken_bubble", 32'(bus.ex_valid), 32'd0);
    gap(2);
    issue(mk(1, 4'b1001, 2, 0, 0));
    step(mk(1, 4'b0100, 1, 2, 3), 1'b0, 1'b0, t);
    chk("brz_not_taken", 32'(s_flush), 32'd0);
    #1;
    chk("brz_nt_ex_valid", 32'(bus.ex_valid), 32'd1);
    gap(3);

    // JM in MEM overrides a simultaneous load-use hazard
    s0 = int'(bus.stall_cnt);
    f0 = int'(bus.flush_cnt);
    issue(mk(1, 4'b1010, 1, 0, 0));
    issue(mk(1, 4'b1110, 2, 0, 9));
    issue(mk(1, 4'b0100, 9, 3, 4));
    chk("jm_flush_mem", 32'(s_fm),    32'd1);
    chk("jm_flush",     32'(s_flush), 32'd1);
    chk("jm_stall",     32'(s_stall), 32'd0);
    #1;
    chk("jm_ex_killed",  32'(bus.ex_valid),  32'd0);
    chk("jm_mem_killed", 32'(bus.mem_valid), 32'd0);
    chk("jm_wb_valid",   32'(bus.wb_valid),  32'd1);
    chk("jm_flush_cnt",  32'(int'(bus.flush_cnt) - f0), 32'd1);
    chk("jm_stall_cnt",  32'(int'(bus.stall_cnt) - s0), 32'd0);
    gap(3);

    // Illegal opcodes: 1101, and an otherwise-ADD with an upper bit set
    issue(mk(1, 5'b01101, 1, 2, 3));
    #1;
    chk("ill_pulse",    32'(bus.illegal),     32'd1);
    chk("ill_ctrl",     32'({bus.ex_ctrl}),   32'h0004);
    chk("ill_ex_valid", 32'(bus.ex_valid),    32'd1);
    gap(1);
    #1;
    chk("ill_one_cycle", 32'(bus.illegal), 32'd0);
    issue(mk(1, 5'b10100, 1, 2, 3));
    #1;
    chk("ill_hibit",      32'(bus.illegal),   32'd1);
    chk("ill_hibit_ctrl", 32'({bus.ex_ctrl}), 32'h0004);
    gap(3);

    // Opcode sweep with varying registers and flags, model-checked
    for (int op = 0; op < 32; op++)
      issue(mk(1, op, op % 4, (op + 1) % 4, (op + 2) % 4), op[0], op[1]);
    gap(4);

    // Counter saturation
    for (int k = 0; k < 34; k++) begin
      issue(mk(1, 4'b1110, 0, 0, 1));
      issue(mk(1, 4'b0100, 1, 1, 2));
    end
    #1;
    chk("stall_cnt_sat", 32'(bus.stall_cnt), 32'(CMAX));
    issue(mk(1, 4'b1110, 0, 0, 1));
    issue(mk(1, 4'b0100, 1, 1, 2));
    #1;
    chk("stall_cnt_held", 32'(bus.stall_cnt), 32'(CMAX));
    for (int k = 0; k < 34; k++) begin
      issue(mk(1, 4'b1000, 0, 0, 0));
      gap(1);
    end
    #1;
    chk("flush_cnt_sat", 32'(bus.flush_cnt), 32'(CMAX));
    gap(3);

    // Asynchronous reset with instructions in flight
    issue(mk(1, 4'b0100, 1, 2, 3));
    issue(mk(1, 4'b0111, 3, 2, 4));
    bus.id_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ex_valid",  32'(bus.ex_valid),  32'd0);
    chk("arst_mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("arst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("arst_flush_cnt", 32'(bus.flush_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    issue(mk(1, 4'b0101, 1, 0, 2));
    issue(mk(1, 4'b0110, 2, 0, 3));
    gap(4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Parametrised pipelined control unit for the 4-bit-opcode accumulator-free register CPU. Decodes the opcode in ID, carries the control word through EX/MEM/WB stage registers, and owns hazard control: load-use stall, branch/jump flush and operand-forwarding selects. It sits between the instruction register (IF/ID) and the datapath, and replaces the single-cycle combinational decoder.

## Interface
- `OPW`, 4: opcode width. Must be ≥4. Any nonzero bit above bit 3 makes the opcode illegal.
- `RAW`, 6: register-address width.
- `CNTW`, 16: width of the performance counters.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: IF/ID holds a real instruction.
- `id_opcode` in OPW: opcode in ID.
- `id_rs`, `id_rt`, `id_rd` in RAW each: register fields in ID.
- `ex_z`, `ex_n` in 1: datapath flag register, sampled while a branch is in EX.
- `stall` out 1: hold PC and IF/ID this cycle.
- `flush` out 1: kill IF/ID contents; PC loads the branch target.
- `flush_mem` out 1: JM resolved in MEM; also kills EX.
- `ex_ctrl`, `mem_ctrl`, `wb_ctrl` out ctrl_t each: registered control word per stage.
- `ex_valid`, `mem_valid`, `wb_valid` out 1 each: stage holds a real instruction.
- `fwd_a`, `fwd_b` out 2 each: EX operand select. 00 = register file, 01 = MEM result, 10 = WB result.
- `illegal` out 1: 1-cycle pulse when an illegal opcode enters EX.
- `stall_cnt`, `flush_cnt` out CNTW each: saturating event counters.

## Operation
- ctrl_t fields: reg_write, mem_to_reg, alu_src1[1:0], alu_src2, branch_n, branch_z, jump, jump_mem, mem_read, mem_write, alu_op[3:0].
- ALU ops: ADD 0000, INC 0001, NEG 0010, SUB 0011, PASS 0100.
- Decode (default word is all zero with alu_op = PASS):
  - NOP 0000: default.
  - SVPC 1111: reg_write, alu_src1 = 01, alu_src2 = 1.
  - LD 1110: reg_write, mem_to_reg, mem_read.
  - ST 0011: mem_write.
  - ADD 0100: reg_write, ADD.
  - INC 0101: reg_write, alu_src1 = 10, INC.
  - NEG 0110: reg_write, NEG.
  - SUB 0111: reg_write, SUB.
  - J 1000: jump.
  - BRZ 1001: branch_z.
  - JM 1010: jump_mem, mem_read.
  - BRN 1011: branch_n.
  - Any other opcode (1100, 1101, or nonzero upper bits): illegal, decoded as NOP but valid = 1.
- Register reads:
  - rs is read by every opcode except NOP and SVPC.
  - rt is read by ADD, SUB and ST.
  - rd is written by SVPC, LD, ADD, INC, NEG and SUB.
- Load-use stall: `stall` = id_valid & ex_valid & ex_ctrl.mem_read & ~ex_ctrl.jump_mem & (ex_rd == id_rs used | ex_rd == id_rt used). On a stall, a bubble enters EX.
- EX redirect: `flush` = ex_valid & (jump | (branch_z & ex_z) | (branch_n & ex_n)). On a flush, a bubble enters EX.
- MEM redirect: `flush_mem` = mem_valid & mem_ctrl.jump_mem. On this, bubbles enter both EX and MEM, and `flush` is also asserted.
- Priority: flush_mem > flush > stall. `stall` is forced to 0 whenever any flush is asserted.
- Forwarding, per operand:
  - Select MEM (01) if mem_valid & mem_reg_write & ~mem_to_reg & mem_rd == ex_rs/ex_rt.
  - Otherwise select WB (10) if wb_valid & wb_reg_write & wb_rd == ex_rs/ex_rt.
  - Otherwise 00.
  - Register 0 is ordinary: no exclusion.
- Counters: stall_cnt increments each cycle `stall` = 1; flush_cnt increments on each `flush` or `flush_mem` cycle (at most +1 per cycle). Both saturate at all-ones.

## Timing
- Reset (async assert, sync release): all stage valids 0, all ctrl words default (alu_op = PASS), stored rs/rt/rd 0, counters 0, illegal 0. The combinational outputs stall, flush, flush_mem and fwd_* then evaluate to 0.
- Latency: an instruction in ID at cycle t appears on ex_* at t+1, mem_* at t+2 and wb_* at t+3 when not stalled or flushed.
- stall, flush, flush_mem and fwd_* are combinational from the stage registers and ID inputs, within the same cycle. illegal is registered.
- A bubble is valid = 0 with the default ctrl word.
- Reset mid-instruction drops all in-flight state; there is no partial commit.

## Structure
- Package `ctrl_pkg`: opcode localparams, ALU-op localparams, `ctrl_t` packed struct, default-word constant.
- Sub-module `ctrl_decode`: combinational opcode to {ctrl_t, illegal, uses_rs, uses_rt, writes_rd}.
- Top: stage registers, hazard/forward logic, counters.

## Test plan
- Reset → after rst_n low: all valids 0, alu_op = 0100, counters 0. After release, a SUB in ID yields ex_ctrl.alu_op = 0011 and reg_write = 1 at t+1.
- LD rd = 5, then ADD rs = 5, rt = 2 → stall = 1 for exactly one cycle, ex_valid = 0 bubble, then ADD in EX with fwd_a = 10; stall_cnt = 1.
- ADD rd = 3, then SUB rs = 3, rt = 3 → no stall; fwd_a = fwd_b = 01.
- BRZ in EX with ex_z = 1 → flush = 1 and the next ex_valid = 0. With ex_z = 0 → flush = 0.
- JM in MEM with load-use hazard in ID/EX the same cycle → flush_mem = 1, flush = 1, stall = 0; flush_cnt +1 only.
- Opcode 1101 → illegal pulses at t+1, ex_ctrl equals the default word; stall_cnt held at 0xFFFF stays 0xFFFF on further stalls.
